// File: rtl/text_grid_renderer_pkg.sv
// Shared constants for the text grid renderer: glyph codes, cell geometry,
// controller states and the glyph bitmap table.
package text_grid_renderer_pkg;

    localparam int unsigned CELL_W = 8;
    localparam int unsigned CELL_H = 16;

    localparam logic [5:0] CHAR_SPACE = 6'd0;
    localparam logic [5:0] CHAR_A     = 6'd1;
    localparam logic [5:0] CHAR_F     = 6'd6;
    localparam logic [5:0] CHAR_T     = 6'd20;
    localparam logic [5:0] CHAR_BLOCK = 6'd63;

    localparam logic [5:0] CLEAR_CHAR_DEFAULT = CHAR_SPACE;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // Glyphs occupy the top 8 rows of the cell; undefined codes render blank.
    function automatic logic [7:0] glyph_row(input logic [5:0] glyph, input logic [3:0] py);
        logic [7:0] r;
        r = 8'h00;
        if (glyph == CHAR_BLOCK) begin
            r = 8'hFF;
        end else if (py < 4'd8) begin
            case (glyph)
                CHAR_A: begin
                    case (py[2:0])
                        3'd0:    r = 8'h18;
                        3'd1:    r = 8'h3C;
                        3'd4:    r = 8'h7E;
                        default: r = 8'h66;
                    endcase
                end
                CHAR_F: begin
                    case (py[2:0])
                        3'd0:    r = 8'h7E;
                        3'd3:    r = 8'h7C;
                        3'd7:    r = 8'h00;
                        default: r = 8'h60;
                    endcase
                end
                CHAR_T:  r = (py[2:0] == 3'd0) ? 8'hFE : 8'h38;
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/text_grid_renderer_if.sv
// Host-side character write bus of the text grid renderer.
interface text_grid_renderer_if;

    logic [7:0] w_h_addr;
    logic [7:0] w_v_addr;
    logic [5:0] w_data;
    logic       w_en;
    logic       clear;
    logic       busy;

    modport master (
        output w_h_addr, w_v_addr, w_data, w_en, clear,
        input  busy
    );

    modport slave (
        input  w_h_addr, w_v_addr, w_data, w_en, clear,
        output busy
    );

endinterface

// File: rtl/text_grid_renderer_font_glyph_rom.sv
// Font lookup: one 8-pixel glyph row per cycle, registered read.
module font_glyph_rom
    import text_grid_renderer_pkg::*;
(
    input  logic       clk,
    input  logic [5:0] glyph,
    input  logic [3:0] py,
    output logic [7:0] row
);

    always_ff @(posedge clk) begin
        row <= glyph_row(glyph, py);
    end

endmodule

// File: rtl/text_grid_renderer.sv
// Character-cell text overlay: host-written glyph buffer scanned out as a
// 1-bit pixel stream three cycles behind the VGA counters.
module text_grid_renderer
    import text_grid_renderer_pkg::*;
#(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter logic [5:0]  CLEAR_CHAR = CLEAR_CHAR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    text_grid_renderer_if.slave   bus,
    input  logic [10:0]           h_ctr,
    input  logic [10:0]           v_ctr,
    output logic                  pixel_on
);

    localparam int unsigned CELLS    = COLS * ROWS;
    localparam logic [11:0] LAST_IDX = 12'(CELLS - 1);
    localparam logic [7:0]  COLS_B   = 8'(COLS);
    localparam logic [7:0]  ROWS_B   = 8'(ROWS);
    localparam logic [10:0] ACT_W    = 11'(COLS * CELL_W);
    localparam logic [10:0] ACT_H    = 11'(ROWS * CELL_H);

    logic [5:0]  mem [CELLS];

    state_t      state;
    logic [11:0] sweep_idx;
    logic        busy;

    logic        wr_en;
    logic [11:0] wr_idx;
    logic [5:0]  wr_data;
    logic [11:0] host_idx;
    logic        host_in_range;

    logic [6:0]  col_s1;
    logic [4:0]  row_s1;
    logic [2:0]  px_s1, px_s2, px_s3;
    logic [3:0]  py_s1, py_s2;
    logic        act_s1, act_s2, act_s3;
    logic [11:0] rd_idx;
    logic [5:0]  glyph_s2;
    logic [7:0]  font_row;

    assign bus.busy = busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_CLEAR;
            sweep_idx <= '0;
            busy      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clear) begin
                        state     <= ST_CLEAR;
                        sweep_idx <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (bus.clear) begin
                        sweep_idx <= '0;
                    end else if (sweep_idx == LAST_IDX) begin
                        state     <= ST_IDLE;
                        sweep_idx <= '0;
                        busy      <= 1'b0;
                    end else begin
                        sweep_idx <= sweep_idx + 12'd1;
                    end
                end
            endcase
        end
    end

    assign host_in_range = (bus.w_h_addr < COLS_B) && (bus.w_v_addr < ROWS_B);
    assign host_idx      = 12'(bus.w_v_addr) * 12'(COLS) + 12'(bus.w_h_addr);

    // The sweep owns the single write port; host writes only land while idle.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = sweep_idx;
        wr_data = CLEAR_CHAR;
        if (state == ST_CLEAR) begin
            wr_en = 1'b1;
        end else if (bus.w_en && host_in_range) begin
            wr_en   = 1'b1;
            wr_idx  = host_idx;
            wr_data = bus.w_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_s1 <= 1'b0;
            act_s2 <= 1'b0;
            act_s3 <= 1'b0;
            col_s1 <= '0;
            row_s1 <= '0;
            px_s1  <= '0;
            px_s2  <= '0;
            px_s3  <= '0;
            py_s1  <= '0;
            py_s2  <= '0;
        end else begin
            act_s1 <= (h_ctr < ACT_W) && (v_ctr < ACT_H);
            col_s1 <= h_ctr[9:3];
            row_s1 <= v_ctr[8:4];
            px_s1  <= h_ctr[2:0];
            py_s1  <= v_ctr[3:0];
            act_s2 <= act_s1;
            px_s2  <= px_s1;
            py_s2  <= py_s1;
            act_s3 <= act_s2;
            px_s3  <= px_s2;
        end
    end

    // Blanking coordinates would index past the buffer, so park the read at 0.
    assign rd_idx = act_s1 ? (12'(row_s1) * 12'(COLS) + 12'(col_s1)) : '0;

    // Read-first simple dual-port buffer; contents are defined by the sweep.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        glyph_s2 <= mem[rd_idx];
    end

    font_glyph_rom u_font (
        .clk   (clk),
        .glyph (glyph_s2),
        .py    (py_s2),
        .row   (font_row)
    );

    assign pixel_on = act_s3 & font_row[3'd7 - px_s3];

endmodule

// File: tb/tb_text_grid_renderer.sv
// Scoreboard bench for text_grid_renderer: randomized stimulus against a
// behavioural buffer/sweep/font model.
module tb_text_grid_renderer;
    import text_grid_renderer_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] h_ctr = '0;
    logic [10:0] v_ctr = '0;
    logic        pixel_on;

    text_grid_renderer_if bus();

    text_grid_renderer #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .CLEAR_CHAR (CLEAR_CHAR_DEFAULT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .h_ctr    (h_ctr),
        .v_ctr    (v_ctr),
        .pixel_on (pixel_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit care;
        bit val;
        int h;
        int v;
    } exp_t;

    exp_t pix_q[$];
    exp_t busy_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int mem_m[CELLS];
    int sweep_start = 0;
    bit rst_level   = 1'b0;
    bit busy_at_edge;

    function automatic int rr(int lo, int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // Glyph artwork as drawn: '#' is a lit pixel, leftmost character is px 0.
    function automatic string art(int g, int py);
        string s = "........";
        if (g == int'(CHAR_BLOCK)) return "########";
        if (py >= 8) return s;
        if (g == int'(CHAR_A)) begin
            case (py)
                0:       s = "...##...";
                1:       s = "..####..";
                4:       s = ".######.";
                default: s = ".##..##.";
            endcase
        end else if (g == int'(CHAR_F)) begin
            case (py)
                0:       s = ".######.";
                3:       s = ".#####..";
                7:       s = "........";
                default: s = ".##.....";
            endcase
        end else if (g == int'(CHAR_T)) begin
            s = (py == 0) ? "#######." : "..###...";
        end
        return s;
    endfunction

    function automatic int pick_glyph();
        case ($urandom_range(5, 0))
            0:       return int'(CHAR_SPACE);
            1:       return int'(CHAR_A);
            2:       return int'(CHAR_F);
            3:       return int'(CHAR_T);
            4:       return int'(CHAR_BLOCK);
            default: return 33;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_busy(input int due, input bit val);
        exp_t e;
        e.due = due; e.care = 1'b1; e.val = val; e.h = 0; e.v = 0;
        busy_q.push_back(e);
    endtask

    task automatic push_pix(input int due, input bit care, input bit val, input int h, input int v);
        exp_t e;
        e.due = due; e.care = care; e.val = val; e.h = h; e.v = v;
        pix_q.push_back(e);
    endtask

    // Model of one clock edge. Cell i of a sweep begun at edge s is written at
    // edge s+1+i; busy holds while fewer than CELLS sweep writes have landed.
    task automatic model_edge(input int h, input int v, input bit we, input int wh,
                              input int wv, input int wd, input bit clr);
        int k;
        int g;
        k = cyc;
        if (rst == 1'b0) begin
            sweep_start = k;
            push_busy(k, 1'b1);
            push_pix(k + 2, 1'b1, 1'b0, h, v);
            return;
        end
        if (k - 1 - sweep_start < CELLS)
            mem_m[k - 1 - sweep_start] = int'(CLEAR_CHAR_DEFAULT);
        else if (we && wh < COLS && wv < ROWS)
            mem_m[wv * COLS + wh] = wd;
        if (clr) sweep_start = k;
        push_busy(k, (k - sweep_start) < CELLS);
        if (h >= COLS * 8 || v >= ROWS * 16) begin
            push_pix(k + 2, 1'b1, 1'b0, h, v);
        end else begin
            g = mem_m[(v / 16) * COLS + (h / 8)];
            if (g < 0)
                push_pix(k + 2, 1'b0, 1'b0, h, v);
            else
                push_pix(k + 2, 1'b1, art(g, v % 16).getc(h % 8) == "#", h, v);
        end
    endtask

    task automatic step(input int h, input int v, input bit we, input int wh,
                        input int wv, input int wd, input bit clr);
        exp_t e;
        @(negedge clk);
        h_ctr        = 11'(h);
        v_ctr        = 11'(v);
        bus.w_en     = we;
        bus.w_h_addr = 8'(wh);
        bus.w_v_addr = 8'(wv);
        bus.w_data   = 6'(wd);
        bus.clear    = clr;
        if (rst_level && !rst) begin
            rst = 1'b1;
        end else if (!rst_level && rst) begin
            #2 rst = 1'b0;
            for (int i = 0; i < pix_q.size(); i++) begin
                e = pix_q[i];
                e.care = 1'b1;
                e.val = 1'b0;
                pix_q[i] = e;
            end
            #1;
            check("busy_on_reset_assert", int'(bus.busy), 1);
            check("pixel_on_reset_assert", int'(pixel_on), 0);
        end
        busy_at_edge = bus.busy;
        @(posedge clk);
        cyc++;
        model_edge(h, v, we, wh, wv, wd, clr);
    endtask

    task automatic read_step(input int h, input int v);
        step(h, v, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic scan_cell(input int col, input int row);
        for (int py = 0; py < 16; py++)
            for (int px = 0; px < 8; px++)
                read_step(col * 8 + px, row * 16 + py);
    endtask

    task automatic scan_all_cells();
        for (int c = 0; c < CELLS; c++)
            read_step((c % COLS) * 8 + rr(0, 7), (c / COLS) * 16 + rr(0, 15));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (busy_q.size() > 0 && busy_q[0].due <= cyc) begin
                e = busy_q.pop_front();
                check("busy", int'(bus.busy), int'(e.val));
            end
            while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
                e = pix_q.pop_front();
                if (e.care)
                    check($sformatf("pixel_on h=%0d v=%0d", e.h, e.v), int'(pixel_on), int'(e.val));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        miscompares++;
        $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cnt;
        int wh, wv;
        foreach (mem_m[i]) mem_m[i] = -1;
        bus.w_en = 1'b0; bus.clear = 1'b0;
        bus.w_h_addr = '0; bus.w_v_addr = '0; bus.w_data = '0;
        #1 rst = 1'b0;
        repeat (3) read_step(rr(0, 799), rr(0, 524));

        // Power-up sweep; host writes attempted during it must be dropped.
        rst_level = 1'b1;
        cnt = 0;
        for (int i = 0; i < CELLS + 10; i++) begin
            step(rr(0, 799), rr(0, 524), ($urandom_range(3, 0) == 0), rr(0, 79), rr(0, 29),
                 int'(CHAR_BLOCK), 1'b0);
            if (busy_at_edge) cnt++;
        end
        check("busy_cycles_after_reset", cnt, CELLS);
        scan_all_cells();

        // Single glyph at the origin, scanned across its top row.
        step(700, 500, 1'b1, 0, 0, int'(CHAR_T), 1'b0);
        for (int h = 0; h < 8; h++) read_step(h, 0);

        // Out-of-range writes must not land or wrap.
        step(700, 500, 1'b1, 80, 0, int'(CHAR_BLOCK), 1'b0);
        step(700, 500, 1'b1, 0, 30, int'(CHAR_BLOCK), 1'b0);
        step(700, 500, 1'b1, 255, 255, int'(CHAR_BLOCK), 1'b0);
        scan_cell(0, 0);
        scan_cell(0, 1);

        // Fill the screen with F, then probe the blanking regions.
        for (int c = 0; c < CELLS; c++)
            step(rr(0, 639), rr(0, 479), 1'b1, c % COLS, c / COLS, int'(CHAR_F), 1'b0);
        for (int i = 0; i < 200; i++) read_step(rr(640, 799), rr(0, 524));
        for (int i = 0; i < 200; i++) read_step(rr(0, 799), rr(480, 524));
        for (int i = 0; i < 100; i++) read_step(rr(0, 639), rr(0, 479));

        // Clear, a dropped write at +1000, restart at +1200.
        cnt = 0;
        for (int i = 0; i <= 3700; i++) begin
            step(rr(0, 639), rr(0, 479), (i == 1000), 5, 0, int'(CHAR_A), (i == 0 || i == 1200));
            if (busy_at_edge) cnt++;
        end
        check("busy_cycles_clear_restart", cnt, 1200 + CELLS);
        scan_cell(5, 0);

        // Random writes and reads concentrated on a few cells, with collisions.
        for (int i = 0; i < 2000; i++) begin
            wh = rr(0, 5);
            wv = rr(0, 2);
            if ($urandom_range(4, 0) == 0) begin
                if ($urandom_range(1, 0) == 1) wh = rr(80, 90);
                else wv = rr(30, 40);
            end
            step(rr(0, 47), rr(0, 47), ($urandom_range(1, 0) == 1), wh, wv, pick_glyph(), 1'b0);
        end

        // Mark the tail of the buffer, then reset in the middle of a sweep.
        for (int c = 1400; c < CELLS; c++)
            step(rr(0, 639), rr(0, 479), 1'b1, c % COLS, c / COLS, int'(CHAR_BLOCK), 1'b0);
        step(rr(0, 639), rr(0, 479), 1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 1500; i++) read_step(rr(0, 639), rr(0, 479));
        rst_level = 1'b0;
        repeat (3) read_step(rr(0, 639), rr(0, 479));
        rst_level = 1'b1;
        cnt = 0;
        for (int i = 0; i < CELLS + 10; i++) begin
            read_step(rr(0, 639), rr(0, 479));
            if (busy_at_edge) cnt++;
        end
        check("busy_cycles_after_midsweep_reset", cnt, CELLS);
        scan_all_cells();

        repeat (5) read_step(700, 500);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/text_grid_renderer.md
TEXT_GRID_RENDERER -- requirements
Module: text_grid_renderer

Interface
REQ-001 Parameter: COLS, 80, character columns per row.
REQ-002 Parameter: ROWS, 30, character rows.
REQ-003 Parameter: CLEAR_CHAR, 6'd0, glyph code written by clear sweep.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-006 w_h_addr  input  8  write column.
REQ-007 w_v_addr  input  8  write row.
REQ-008 w_data  input  6  glyph code to store.
REQ-009 w_en  input  1  write strobe, one write per cycle while high.
REQ-010 clear  input  1  single-cycle pulse requesting full-screen clear.
REQ-011 h_ctr  input  11  VGA horizontal pixel counter.
REQ-012 v_ctr  input  11  VGA vertical pixel counter.
REQ-013 pixel_on  output  1  foreground pixel, aligned 3 cycles after h_ctr/v_ctr.
REQ-014 busy  output  1  clear sweep in progress; host writes ignored.

Function
REQ-015 Character buffer SHALL hold COLS*ROWS 6-bit entries, linear index = row*COLS + col.
REQ-016 Glyph cell SHALL be 8x16 pixels: col = h_ctr[9:3], row = v_ctr[8:4], px = h_ctr[2:0], py = v_ctr[3:0].
REQ-017 Write with w_en=1, busy=0, w_h_addr<COLS, w_v_addr<ROWS SHALL update the entry on that edge.
REQ-018 Writes with out-of-range address or busy=1 SHALL be dropped silently, no wrap.
REQ-019 Read pipeline SHALL be 3 stages: S1 register cell/pixel coords and active flag; S2 buffer read; S3 font row read and bit select (bit 7-px, MSB leftmost).
REQ-020 Active flag SHALL be h_ctr<COLS*8 and v_ctr<ROWS*16; pixel_on SHALL be 0 when the stage-3 active flag is 0.
REQ-021 Same-cycle write and read of one entry SHALL return the old value (read-first).
REQ-022 States: IDLE, CLEAR; IDLE->CLEAR on clear=1 or on reset release; CLEAR->IDLE after final index COLS*ROWS-1 written.
REQ-023 CLEAR SHALL write CLEAR_CHAR to one index per cycle from 0 upward; sweep takes exactly COLS*ROWS cycles.
REQ-024 busy SHALL equal (state==CLEAR).
REQ-025 clear asserted while in CLEAR SHALL restart the sweep at index 0.
REQ-026 Display pipeline SHALL keep running during CLEAR, showing partially cleared contents.
REQ-027 Sweep index counter SHALL be 12 bits; no arithmetic overflow at 2400.

Reset
REQ-028 rst low SHALL asynchronously force: pixel_on=0, busy=1, state=CLEAR, sweep index=0, pipeline active flags=0.
REQ-029 Buffer and font ROM contents SHALL not be reset; the post-reset sweep provides defined buffer contents.
REQ-030 Reset asserted mid-sweep SHALL restart the sweep from index 0 after release.

Structure
REQ-031 CHAR_* glyph codes, cell dimensions (8, 16) and CLEAR_CHAR default SHALL live in the shared constants include.
REQ-032 Font lookup SHALL be a sub-module font_glyph_rom (inputs glyph 6b, py 4b; output row 8b; one-cycle registered read).
REQ-033 Buffer SHALL be inferable as one simple dual-port block RAM (one write, one read port).

Verification
REQ-034 Reset release, run 2400 cycles -> busy=1 for exactly 2400 cycles then 0; every cell reads CLEAR_CHAR.
REQ-035 After clear, write (h=0,v=0,CHAR_T); scan h_ctr 0..7, v_ctr 0 -> pixel_on matches font row 0 of CHAR_T, 3 cycles after each counter value.
REQ-036 Write (h=80,v=0) and (h=0,v=30) -> buffer unchanged, pixel_on at cells (0,0) unaffected.
REQ-037 Pulse clear, at cycle 1000 write (h=5,v=0,CHAR_A), then clear again at cycle 1200 -> write dropped, sweep restarts, busy lasts 1200+2400 cycles total.
REQ-038 h_ctr=640..799 or v_ctr=480..524 with all cells CHAR_F -> pixel_on=0.
REQ-039 Assert rst low at sweep index 1500 -> pixel_on=0, busy=1 immediately; after release sweep runs full 2400 cycles.
